tile_map_bitmap: RTL and testbench

//  Parametrised, writable two-level tile map for the playfield (solid columns, destructible bricks).

---
 rtl/tile_map_bitmap.sv | 200 ++++++++++++++++++++
 tb/tb_tile_map_bitmap.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tile_map_bitmap.sv
// Writable MAP_ROWS x MAP_COLS tile map with default-level reload sequencer and 1-cycle pixel renderer.
// Optional collision query port enabled by defining COLLISION_QUERY_EN.
module tile_map_bitmap #(
  parameter int         TILE_X_BITS  = 5,
  parameter int         TILE_Y_BITS  = 5,
  parameter int         MAP_COLS     = 17,
  parameter int         MAP_ROWS     = 11,
  parameter logic [7:0] WALL_COLOR   = 8'hE0,
  parameter logic [7:0] BRICK_COLOR  = 8'h8C,
  parameter logic [7:0] MORTAR_COLOR = 8'h49,
  parameter logic [7:0] TRANSPARENT  = 8'hFF,
  localparam int        COL_W        = $clog2(MAP_COLS),
  localparam int        ROW_W        = $clog2(MAP_ROWS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      offsetX,
  input  logic [10:0]      offsetY,
  input  logic             InsideRectangle,
  input  logic             load_level,
  input  logic             wr_en,
  input  logic [COL_W-1:0] wr_col,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [1:0]       wr_type,
  output logic             wr_ack,
  output logic             wr_err,
  output logic             busy,
  output logic             drawingRequest,
  output logic [7:0]       RGBout
`ifdef COLLISION_QUERY_EN
  ,
  input  logic [COL_W-1:0] q_col,
  input  logic [ROW_W-1:0] q_row,
  output logic [1:0]       q_type
`endif
);

  localparam int NX = TILE_X_BITS + COL_W;
  localparam int NY = TILE_Y_BITS + ROW_W;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(MAP_COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MAP_ROWS - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_RELOAD = 1'b1} state_t;

  state_t           state_r;
  logic [COL_W-1:0] col_r;
  logic [ROW_W-1:0] row_r;
  logic [1:0]       cells_r [MAP_ROWS][MAP_COLS];

  logic             wr_ok_s;
  logic             cell_we_s;
  logic [ROW_W-1:0] cell_row_s;
  logic [COL_W-1:0] cell_col_s;
  logic [1:0]       cell_wd_s;

  logic [COL_W-1:0] mc_s, mc_idx_s;
  logic [ROW_W-1:0] mr_s, mr_idx_s;
  logic             pix_in_map_s;
  logic [1:0]       pix_cell_s;
  logic             mortar_s;
  logic [7:0]       pix_s;

  // Level layout: solid pillars on even/even, clear spawn corner, bricks on every third diagonal.
  function automatic logic [1:0] default_code(input int r, input int c);
    if ((r % 2 == 0) && (c % 2 == 0)) begin
      return 2'd1;
    end else if ((r < 2) && (c < 2)) begin
      return 2'd0;
    end else if ((r + c) % 3 == 0) begin
      return 2'd2;
    end else begin
      return 2'd0;
    end
  endfunction

  assign busy           = (state_r == ST_RELOAD);
  assign drawingRequest = (RGBout != TRANSPARENT);

  // A load request in the same cycle pre-empts the write.
  assign wr_ok_s = !reset && wr_en && (state_r == ST_IDLE) && !load_level &&
                   (int'(wr_col) < MAP_COLS) && (int'(wr_row) < MAP_ROWS);

  // Select the single cell write for this cycle: reload sequencer or game write port.
  always_comb begin
    cell_we_s  = 1'b0;
    cell_row_s = row_r;
    cell_col_s = col_r;
    cell_wd_s  = default_code(int'(row_r), int'(col_r));
    if (reset) begin
      cell_we_s = 1'b0;
    end else if (state_r == ST_RELOAD) begin
      cell_we_s = 1'b1;
    end else if (wr_ok_s) begin
      cell_we_s  = 1'b1;
      cell_row_s = wr_row;
      cell_col_s = wr_col;
      cell_wd_s  = wr_type;
    end else begin
      cell_we_s = 1'b0;
    end
  end

  // Cell storage, no reset so it can map onto RAM/LUT storage.
  always_ff @(posedge clk) begin
    if (cell_we_s) begin
      cells_r[cell_row_s][cell_col_s] <= cell_wd_s;
    end
  end

  assign mc_s         = offsetX[TILE_X_BITS +: COL_W];
  assign mr_s         = offsetY[TILE_Y_BITS +: ROW_W];
  assign pix_in_map_s = ((offsetX >> NX) == 11'd0) && ((offsetY >> NY) == 11'd0) &&
                        (int'(mc_s) < MAP_COLS) && (int'(mr_s) < MAP_ROWS);
  assign mc_idx_s     = (int'(mc_s) < MAP_COLS) ? mc_s : COL_W'(0);
  assign mr_idx_s     = (int'(mr_s) < MAP_ROWS) ? mr_s : ROW_W'(0);
  assign pix_cell_s   = cells_r[mr_idx_s][mc_idx_s];

  // Brick courses are 8 px tall; odd courses (py[3]) shift the head joints to a 32 px pitch.
  assign mortar_s = (offsetY[2:0] == 3'd0) ||
                    (offsetY[3] ? (offsetX[4:0] == 5'd0) : (offsetX[3:0] == 4'd0));

  // Next pixel colour from the addressed cell.
  always_comb begin
    pix_s = TRANSPARENT;
    if (!InsideRectangle || busy || !pix_in_map_s) begin
      pix_s = TRANSPARENT;
    end else begin
      case (pix_cell_s)
        2'd1:    pix_s = WALL_COLOR;
        2'd2:    pix_s = mortar_s ? MORTAR_COLOR : BRICK_COLOR;
        default: pix_s = TRANSPARENT;
      endcase
    end
  end

  // Reload sequencer FSM with registered pixel and write-handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_RELOAD;
      row_r   <= ROW_W'(0);
      col_r   <= COL_W'(0);
      RGBout  <= TRANSPARENT;
      wr_ack  <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      RGBout <= pix_s;
      wr_ack <= wr_ok_s;
      wr_err <= wr_en && !wr_ok_s;
      case (state_r)
        ST_IDLE: begin
          if (load_level) begin
            state_r <= ST_RELOAD;
            row_r   <= ROW_W'(0);
            col_r   <= COL_W'(0);
          end
        end
        ST_RELOAD: begin
          if (load_level) begin
            row_r <= ROW_W'(0);
            col_r <= COL_W'(0);
          end else if ((row_r == LAST_ROW) && (col_r == LAST_COL)) begin
            state_r <= ST_IDLE;
            row_r   <= ROW_W'(0);
            col_r   <= COL_W'(0);
          end else if (col_r == LAST_COL) begin
            col_r <= COL_W'(0);
            row_r <= row_r + ROW_W'(1);
          end else begin
            col_r <= col_r + COL_W'(1);
          end
        end
        default: begin
          state_r <= ST_RELOAD;
          row_r   <= ROW_W'(0);
          col_r   <= COL_W'(0);
        end
      endcase
    end
  end

`ifdef COLLISION_QUERY_EN
  logic             q_in_map_s;
  logic [1:0]       q_cell_s;

  assign q_in_map_s = (int'(q_col) < MAP_COLS) && (int'(q_row) < MAP_ROWS);
  assign q_cell_s   = cells_r[q_in_map_s ? q_row : ROW_W'(0)][q_in_map_s ? q_col : COL_W'(0)];

  // Collision answer; anything unknown reads as solid so movers stay put.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_type <= 2'd1;
    end else if (busy || !q_in_map_s) begin
      q_type <= 2'd1;
    end else begin
      q_type <= q_cell_s;
    end
  end
`endif

endmodule

// File: tb/tb_tile_map_bitmap.sv
// Self-checking bench for tile_map_bitmap: directed steps plus randomized pixels/writes against a map model.
// Query-port checks compile in when COLLISION_QUERY_EN is defined.
module tb_tile_map_bitmap;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] offsetX, offsetY;
  logic        InsideRectangle, load_level, wr_en;
  logic [4:0]  wr_col;
  logic [3:0]  wr_row;
  logic [1:0]  wr_type;
  logic        wr_ack, wr_err, busy, drawingRequest;
  logic [7:0]  RGBout;
  logic [4:0]  q_col;
  logic [3:0]  q_row;
`ifdef COLLISION_QUERY_EN
  logic [1:0]  q_type;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int mmap [11][17];

  tile_map_bitmap dut (
    .clk(clk), .reset(reset), .offsetX(offsetX), .offsetY(offsetY),
    .InsideRectangle(InsideRectangle), .load_level(load_level),
    .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_type(wr_type),
    .wr_ack(wr_ack), .wr_err(wr_err), .busy(busy),
    .drawingRequest(drawingRequest), .RGBout(RGBout)
`ifdef COLLISION_QUERY_EN
    , .q_col(q_col), .q_row(q_row), .q_type(q_type)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int level_code(input int r, input int c);
    if (r % 2 == 0 && c % 2 == 0) return 1;
    if (r < 2 && c < 2) return 0;
    if ((r + c) % 3 == 0) return 2;
    return 0;
  endfunction

  task automatic model_reload();
    for (int r = 0; r < 11; r++)
      for (int c = 0; c < 17; c++)
        mmap[r][c] = level_code(r, c);
  endtask

  function automatic logic [7:0] model_pix(input int ox, input int oy, input bit ins, input bit bsy);
    int px, py;
    if (!ins || bsy || ox >= 17 * 32 || oy >= 11 * 32) return 8'hFF;
    px = ox % 32;
    py = oy % 32;
    case (mmap[oy / 32][ox / 32])
      1: return 8'hE0;
      2: begin
        if (py % 8 == 0) return 8'h49;
        if ((py / 8) % 2 == 1) return (px == 0) ? 8'h49 : 8'h8C;
        return (px % 16 == 0) ? 8'h49 : 8'h8C;
      end
      default: return 8'hFF;
    endcase
  endfunction

  function automatic int model_q(input int qc, input int qr, input bit bsy);
    if (bsy || qc >= 17 || qr >= 11) return 1;
    return mmap[qr][qc];
  endfunction

  // Count busy cycles (bounded), optionally attempting a write to (0,0) at cycle write_at.
  task automatic count_busy(input int write_at, output int cnt, output bit rgb_bad);
    cnt = 0;
    rgb_bad = 1'b0;
    while (busy && cnt < 400) begin
      if (RGBout !== 8'hFF) rgb_bad = 1'b1;
      if (cnt == write_at) begin
        wr_en = 1'b1; wr_col = 5'd0; wr_row = 4'd0; wr_type = 2'd0;
      end
      step();
      if (cnt == write_at) begin
        wr_en = 1'b0;
        check("busy_wr_err", wr_err, 1'b1);
        check("busy_wr_ack", wr_ack, 1'b0);
`ifdef COLLISION_QUERY_EN
        check("q_during_reload", q_type, model_q(int'(q_col), int'(q_row), 1'b1));
`endif
      end
      cnt++;
    end
  endtask

  task automatic pix(input int ox, input int oy, input string tag, input logic [7:0] exp);
    offsetX = 11'(ox);
    offsetY = 11'(oy);
    step();
    check(tag, RGBout, exp);
    check({tag, "_dreq"}, drawingRequest, exp != 8'hFF);
  endtask

  initial begin
    int cnt, ox, oy, wc, wrr, wt, qc, qr;
    bit bad, ins, we, ok;
    logic [7:0] exp_p;
    int exp_q;

    reset = 1'b1; offsetX = 11'd0; offsetY = 11'd0; InsideRectangle = 1'b1;
    load_level = 1'b0; wr_en = 1'b0; wr_col = 5'd0; wr_row = 4'd0; wr_type = 2'd0;
    q_col = 5'd1; q_row = 4'd0;
    model_reload();

    repeat (3) step();
    check("rst_rgb", RGBout, 8'hFF);
    check("rst_ack", wr_ack, 1'b0);
    check("rst_err", wr_err, 1'b0);
    check("rst_busy", busy, 1'b1);
`ifdef COLLISION_QUERY_EN
    check("rst_q", q_type, 2'd1);
`endif
    reset = 1'b0;
    count_busy(-1, cnt, bad);
    check("reload_cycles", cnt, 187);
    check("reload_rgb_ff", bad, 1'b0);

    pix(0, 0, "px_wall", 8'hE0);
    pix(32, 0, "px_spawn", 8'hFF);
    pix(96, 0, "px_mortar", 8'h49);
    pix(100, 10, "px_brick", 8'h8C);

    wr_en = 1'b1; wr_col = 5'd3; wr_row = 4'd0; wr_type = 2'd0;
    step();
    wr_en = 1'b0;
    check("wr_ack", wr_ack, 1'b1);
    check("wr_err_clr", wr_err, 1'b0);
    mmap[0][3] = 0;
    pix(100, 10, "px_after_wr", 8'hFF);

    wr_en = 1'b1; wr_col = 5'd17; wr_row = 4'd0; wr_type = 2'd1;
    step();
    wr_en = 1'b0;
    check("oor_err", wr_err, 1'b1);
    check("oor_ack", wr_ack, 1'b0);

    pix(544, 0, "px_col_oor", 8'hFF);
    pix(0, 352, "px_row_oor", 8'hFF);
    InsideRectangle = 1'b0;
    pix(0, 0, "px_outside", 8'hFF);
    InsideRectangle = 1'b1;

`ifdef COLLISION_QUERY_EN
    q_col = 5'd0; q_row = 4'd0; step(); check("q_solid", q_type, 2'd1);
    q_col = 5'd1; q_row = 4'd0; step(); check("q_empty", q_type, 2'd0);
    q_col = 5'd20; q_row = 4'd0; step(); check("q_oor", q_type, 2'd1);
`endif

    for (int i = 0; i < 400; i++) begin
      ox  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 600));
      oy  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 400));
      ins = ($urandom_range(0, 9) != 0);
      we  = ($urandom_range(0, 2) == 0);
      wc  = $urandom_range(0, 18);
      wrr = $urandom_range(0, 12);
      wt  = $urandom_range(0, 3);
      qc  = $urandom_range(0, 20);
      qr  = $urandom_range(0, 13);
      offsetX = 11'(ox); offsetY = 11'(oy); InsideRectangle = ins;
      wr_en = we; wr_col = 5'(wc); wr_row = 4'(wrr); wr_type = 2'(wt);
      q_col = 5'(qc); q_row = 4'(qr);
      exp_p = model_pix(ox, oy, ins, 1'b0);
      exp_q = model_q(qc, qr, 1'b0);
      ok = we && wc < 17 && wrr < 11;
      step();
      if (ok) mmap[wrr][wc] = wt;
      check("rnd_rgb", RGBout, exp_p);
      check("rnd_dreq", drawingRequest, exp_p != 8'hFF);
      check("rnd_ack", wr_ack, ok);
      check("rnd_err", wr_err, we && !ok);
`ifdef COLLISION_QUERY_EN
      check("rnd_q", q_type, exp_q);
`endif
    end
    wr_en = 1'b0; InsideRectangle = 1'b1;
    q_col = 5'd1; q_row = 4'd0;

    wr_en = 1'b1; wr_col = 5'd0; wr_row = 4'd0; wr_type = 2'd0; load_level = 1'b1;
    step();
    wr_en = 1'b0; load_level = 1'b0;
    check("load_wr_err", wr_err, 1'b1);
    check("load_wr_ack", wr_ack, 1'b0);
    check("load_busy", busy, 1'b1);
    repeat (40) step();
    check("mid_busy", busy, 1'b1);
    load_level = 1'b1;
    step();
    load_level = 1'b0;
    count_busy(30, cnt, bad);
    check("restart_cycles", cnt, 187);
    check("restart_rgb_ff", bad, 1'b0);
    model_reload();
    pix(0, 0, "px_wall_kept", 8'hE0);
    pix(96, 0, "px_brick_restored", 8'h49);
    pix(100, 10, "px_brick_body", 8'h8C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
